// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment patterns (abcdefg, active-high) and special codes
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'b1111110;
  localparam logic [6:0] SEG_1    = 7'b0110000;
  localparam logic [6:0] SEG_2    = 7'b1101101;
  localparam logic [6:0] SEG_3    = 7'b1111001;
  localparam logic [6:0] SEG_4    = 7'b0110011;
  localparam logic [6:0] SEG_5    = 7'b1011011;
  localparam logic [6:0] SEG_6    = 7'b1011111;
  localparam logic [6:0] SEG_7    = 7'b1110000;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1111011;
  localparam logic [6:0] SEG_DASH = 7'b0000001;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

endpackage

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - combinational segment pattern to BCD code decoder
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       err
);

  always_comb begin
    code = CODE_ERR;
    err  = 1'b1;
    case (seg)
      SEG_0:    begin code = 4'd0;       err = 1'b0; end
      SEG_1:    begin code = 4'd1;       err = 1'b0; end
      SEG_2:    begin code = 4'd2;       err = 1'b0; end
      SEG_3:    begin code = 4'd3;       err = 1'b0; end
      SEG_4:    begin code = 4'd4;       err = 1'b0; end
      SEG_5:    begin code = 4'd5;       err = 1'b0; end
      SEG_6:    begin code = 4'd6;       err = 1'b0; end
      SEG_7:    begin code = 4'd7;       err = 1'b0; end
      SEG_8:    begin code = 4'd8;       err = 1'b0; end
      SEG_9:    begin code = 4'd9;       err = 1'b0; end
      SEG_DASH: begin code = CODE_BLANK; err = 1'b0; end
      default:  begin code = CODE_ERR;   err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// rtl/seg7_scan_capture.sv - debounces a multiplexed 7-segment bus and publishes
// recovered BCD digits as atomic frames
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg7_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_valid,
  output logic                  frame_err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [6:0]          seg_q;
  logic [DIGITS-1:0]   sel_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic                change;
  logic                cap;
  logic [6:0]          cap_seg;
  logic [DIGITS-1:0]   cap_sel;
  logic [3:0]          dec_code;
  logic                dec_err;
  logic [4*DIGITS-1:0] shadow_q;
  logic [DIGITS-1:0]   shadow_err_q;
  logic [DIGITS-1:0]   mask_q;
  logic                mask_full;

  // Reset clears the sample to zero and the count to zero, so the first edge
  // always lands on count 1 exactly as a change would.
  assign change = (seg7_in != seg_q) || (dig_sel != sel_q);

  always_comb begin
    cnt_d = cnt_q;
    if (change)
      cnt_d = CW'(1);
    else if (cnt_q != CNT_MAX)
      cnt_d = cnt_q + CW'(1);
  end

  // Capture happens on the edge the count arrives at the threshold. With a
  // one-cycle threshold that edge is the one that samples the new value, so the
  // live bus is decoded; otherwise the sample register already equals the bus.
  assign cap_seg = (STABLE_CYCLES == 1) ? seg7_in : seg_q;
  assign cap_sel = (STABLE_CYCLES == 1) ? dig_sel : sel_q;
  assign cap     = (cnt_d == CNT_MAX) && (change || (cnt_q != CNT_MAX)) && $onehot(cap_sel);

  seg7_to_bcd u_dec (
    .seg  (cap_seg),
    .code (dec_code),
    .err  (dec_err)
  );

  assign mask_full = &mask_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q        <= '0;
      sel_q        <= '0;
      cnt_q        <= '0;
      mask_q       <= '0;
      shadow_q     <= {DIGITS{CODE_BLANK}};
      shadow_err_q <= '0;
      bcd_out      <= {DIGITS{CODE_BLANK}};
      digit_err    <= '0;
      frame_valid  <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      seg_q <= seg7_in;
      sel_q <= dig_sel;
      cnt_q <= cnt_d;

      for (int i = 0; i < DIGITS; i++) begin
        if (cap && cap_sel[i]) begin
          shadow_q[4*i +: 4] <= dec_code;
          shadow_err_q[i]    <= dec_err;
        end
      end

      // A capture on the publish edge survives into the next frame's mask.
      mask_q      <= (mask_full ? '0 : mask_q) | (cap ? cap_sel : '0);
      frame_valid <= mask_full;
      if (mask_full) begin
        bcd_out   <= shadow_q;
        digit_err <= shadow_err_q;
        frame_err <= |shadow_err_q;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb/tb_seg7_scan_capture.sv - scoreboard bench for seg7_scan_capture
module tb_seg7_scan_capture;
  import seg7_pkg::*;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  err;
  } frame_t;

  typedef struct {
    logic [7:0] bcd;
    logic [1:0] err;
  } frame1_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg7_in;
  logic [3:0]  dig_sel;
  logic [15:0] bcd_out;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        frame_err;

  logic [6:0]  s1_seg;
  logic [1:0]  s1_sel;
  logic [7:0]  s1_bcd;
  logic [1:0]  s1_derr;
  logic        s1_fv;
  logic        s1_ferr;

  int passed = 0;
  int total  = 0;
  int frames_seen  = 0;
  int frames1_seen = 0;
  frame_t  exp_q[$];
  frame1_t exp1_q[$];

  seg7_scan_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg7_in     (seg7_in),
    .dig_sel     (dig_sel),
    .bcd_out     (bcd_out),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  seg7_scan_capture #(.DIGITS(2), .STABLE_CYCLES(1)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .seg7_in     (s1_seg),
    .dig_sel     (s1_sel),
    .bcd_out     (s1_bcd),
    .digit_err   (s1_derr),
    .frame_valid (s1_fv),
    .frame_err   (s1_ferr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
    seg7_in = s;
    dig_sel = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] b, input logic [3:0] e);
    frame_t f;
    f.bcd = b;
    f.err = e;
    exp_q.push_back(f);
  endtask

  always @(negedge clk) begin
    if (!rst && frame_valid) begin
      frame_t f;
      frames_seen++;
      check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        f = exp_q.pop_front();
        check("bcd_out", 32'(bcd_out), 32'(f.bcd));
        check("digit_err", 32'(digit_err), 32'(f.err));
        check("frame_err", 32'(frame_err), 32'(|f.err));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && s1_fv) begin
      frame1_t f;
      frames1_seen++;
      check("s1_frame_expected", 32'(exp1_q.size() != 0), 32'd1);
      if (exp1_q.size() != 0) begin
        f = exp1_q.pop_front();
        check("s1_bcd_out", 32'(s1_bcd), 32'(f.bcd));
        check("s1_digit_err", 32'(s1_derr), 32'(f.err));
        check("s1_frame_err", 32'(s1_ferr), 32'(|f.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    frame1_t g;
    seg7_in = '0;
    dig_sel = '0;
    s1_seg  = '0;
    s1_sel  = '0;
    rst     = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_bcd_out", 32'(bcd_out), 32'hFFFF);
    check("rst_digit_err", 32'(digit_err), 32'h0);
    check("rst_frame_valid", 32'(frame_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    rst = 1'b0;

    // Full frame
    push(16'h0543, 4'b0000);
    hold(SEG_3, 4'b0001, 4);
    hold(SEG_4, 4'b0010, 4);
    hold(SEG_5, 4'b0100, 4);
    hold(SEG_0, 4'b1000, 4);
    hold(7'd0, 4'b0000, 3);
    check("frames_after_full", 32'(frames_seen), 32'd1);

    // Debounce: 3-clk dwell is ignored, 10-clk dwell captures once
    hold(SEG_7, 4'b0001, 3);
    hold(SEG_1, 4'b0010, 4);
    hold(SEG_2, 4'b0100, 4);
    hold(SEG_8, 4'b1000, 4);
    hold(7'd0, 4'b0000, 6);
    check("frames_after_short", 32'(frames_seen), 32'd1);
    check("mask_after_short", 32'(dut.mask_q), 32'b1110);
    push(16'h8216, 4'b0000);
    hold(SEG_6, 4'b0001, 10);
    hold(7'd0, 4'b0000, 3);
    check("frames_after_long", 32'(frames_seen), 32'd2);
    check("mask_after_long", 32'(dut.mask_q), 32'b0000);

    // Illegal pattern and dash
    push(16'h2EF9, 4'b0100);
    hold(SEG_9, 4'b0001, 4);
    hold(SEG_DASH, 4'b0010, 4);
    hold(7'b1000000, 4'b0100, 4);
    hold(SEG_2, 4'b1000, 4);
    hold(7'd0, 4'b0000, 3);
    check("frames_after_illegal", 32'(frames_seen), 32'd3);

    // Bad select
    hold(SEG_3, 4'b0000, 8);
    hold(SEG_3, 4'b0011, 8);
    check("mask_after_badsel", 32'(dut.mask_q), 32'b0000);
    check("frames_after_badsel", 32'(frames_seen), 32'd3);

    // Overwrite: digit1 7 then 9
    push(16'h4391, 4'b0000);
    hold(SEG_7, 4'b0010, 4);
    hold(SEG_1, 4'b0001, 4);
    hold(SEG_9, 4'b0010, 4);
    hold(SEG_3, 4'b0100, 4);
    hold(SEG_4, 4'b1000, 4);
    hold(7'd0, 4'b0000, 3);
    check("frames_after_overwrite", 32'(frames_seen), 32'd4);

    // Async reset mid-frame
    hold(SEG_8, 4'b0001, 4);
    check("mask_partial", 32'(dut.mask_q), 32'b0001);
    #2 rst = 1'b1;
    #1;
    check("midrst_bcd_out", 32'(bcd_out), 32'hFFFF);
    check("midrst_digit_err", 32'(digit_err), 32'h0);
    check("midrst_frame_valid", 32'(frame_valid), 32'h0);
    check("midrst_frame_err", 32'(frame_err), 32'h0);
    check("midrst_mask", 32'(dut.mask_q), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    hold(SEG_1, 4'b0010, 4);
    hold(SEG_2, 4'b0100, 4);
    hold(SEG_3, 4'b1000, 4);
    hold(7'd0, 4'b0000, 4);
    check("frames_after_rst_partial", 32'(frames_seen), 32'd4);
    check("mask_after_rst_partial", 32'(dut.mask_q), 32'b1110);
    push(16'h3214, 4'b0000);
    hold(SEG_4, 4'b0001, 4);
    hold(7'd0, 4'b0000, 3);
    check("frames_after_rst_full", 32'(frames_seen), 32'd5);

    // Single-cycle threshold: capture coinciding with publish carries over
    g.bcd = 8'h21; g.err = 2'b00; exp1_q.push_back(g);
    g.bcd = 8'h43; g.err = 2'b00; exp1_q.push_back(g);
    s1_seg = SEG_1; s1_sel = 2'b01; @(negedge clk);
    s1_seg = SEG_2; s1_sel = 2'b10; @(negedge clk);
    s1_seg = SEG_3; s1_sel = 2'b01; @(negedge clk);
    check("s1_mask_carry", 32'(dut1.mask_q), 32'b01);
    s1_seg = SEG_4; s1_sel = 2'b10; repeat (3) @(negedge clk);
    s1_seg = '0; s1_sel = 2'b00; repeat (3) @(negedge clk);
    check("s1_frames", 32'(frames1_seen), 32'd2);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("s1_queue_drained", 32'(exp1_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
